zelda_sprite_fetch: RTL and testbench

//  Per-pixel sprite fetch stage directly upstream of the Zelda palette lookup. From the VGA beam position
//  and Link's position/direction, computes the sprite ROM address and emits a 4-bit palette index.

---
 rtl/zelda_sprite_pkg.sv | 29 ++
 rtl/zelda_anim_ctrl.sv | 92 +++++++++
 rtl/zelda_sprite_fetch.sv | 135 +++++++++++++
 tb/tb_zelda_sprite_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zelda_sprite_pkg.sv
// ----------------------------------------------------------------------------
// zelda_sprite_pkg
// Shared types and constants for the Zelda sprite fetch stage.
//   dir_t           : Link's facing direction, encoded as the top field of the
//                     sprite ROM address (DOWN=0 UP=1 LEFT=2 RIGHT=3).
//   anim_state_t    : walk animation controller states.
//   TRANSPARENT_IDX : palette index treated as "no pixel".
//   DEF_SPR_W/H     : default sprite box size in pixels.
// Optional feature macro used by the top level: MIRROR_LEFT_EN.
// ----------------------------------------------------------------------------
package zelda_sprite_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        ANIM_IDLE = 1'b0,
        ANIM_WALK = 1'b1
    } anim_state_t;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
    localparam int         DEF_SPR_W       = 16;
    localparam int         DEF_SPR_H       = 16;

endpackage

// File: rtl/zelda_anim_ctrl.sv
// ----------------------------------------------------------------------------
// zelda_anim_ctrl
// Walk animation controller. Advances only on frame_start pulses, using the
// moving flag sampled on that same pulse.
// Ports:
//   Clk         in   pixel clock
//   Reset       in   synchronous, active-high
//   frame_start in   1-cycle pulse at start of vertical blank
//   moving      in   Link is walking (sampled on frame_start)
//   frame       out  current walk frame index, stable for a whole video frame
// ----------------------------------------------------------------------------
module zelda_anim_ctrl
    import zelda_sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 2,
    parameter int ANIM_DIV   = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_start,
    input  logic                          moving,
    output logic [$clog2(NUM_FRAMES)-1:0] frame
);

    localparam int FW = $clog2(NUM_FRAMES);
    // A divide-by-1 still needs a 1-bit counter that simply stays at 0.
    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    anim_state_t   state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [DW-1:0] div_q,   div_d;
    logic [FW-1:0] frame_step;
    logic [DW-1:0] div_step;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ANIM_IDLE;
            frame_q <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        div_d   = div_q;

        // One animation step; frame wraps naturally since NUM_FRAMES is 2^FW.
        frame_step = frame_q;
        div_step   = div_q + 1'b1;
        if (div_q == DW'(ANIM_DIV - 1)) begin
            div_step   = '0;
            frame_step = frame_q + 1'b1;
        end

        if (frame_start) begin
            case (state_q)
                ANIM_IDLE: begin
                    // The pulse that starts the walk counts as its first step
                    // (frame/div are already 0 here).
                    if (moving) begin
                        state_d = ANIM_WALK;
                        frame_d = frame_step;
                        div_d   = div_step;
                    end
                end
                ANIM_WALK: begin
                    if (!moving) begin
                        state_d = ANIM_IDLE;
                        frame_d = '0;
                        div_d   = '0;
                    end else begin
                        frame_d = frame_step;
                        div_d   = div_step;
                    end
                end
                default: begin
                    state_d = ANIM_IDLE;
                    frame_d = '0;
                    div_d   = '0;
                end
            endcase
        end
    end

    assign frame = frame_q;

endmodule

// File: rtl/zelda_sprite_fetch.sv
// ----------------------------------------------------------------------------
// zelda_sprite_fetch
// Per-pixel sprite fetch stage feeding the palette lookup. Turns the beam
// position and Link's per-frame state into a sprite ROM address, then returns
// the ROM's palette index with a hit flag, 2 cycles after the pixel.
// Ports:
//   Clk, Reset            pixel clock, synchronous active-high reset
//   frame_start           start-of-vblank pulse; latches sprite state
//   pix_valid             draw_x/draw_y is a visible pixel
//   draw_x, draw_y        beam position
//   sprite_x, sprite_y    sprite top-left (latched on frame_start)
//   direction, moving     Link's facing / walking (latched on frame_start)
//   rom_addr              {dir, frame, row, col} to a 1-cycle sync ROM
//   rom_data              ROM read data, valid the cycle after rom_addr
//   pal_index             palette index, 0 when no hit
//   out_hit               in sprite box and not transparent
//   out_valid             pix_valid aligned with pal_index
// Optional feature macro: MIRROR_LEFT_EN -- LEFT reuses the RIGHT artwork
// mirrored horizontally instead of its own ROM region.
// ----------------------------------------------------------------------------
module zelda_sprite_fetch
    import zelda_sprite_pkg::*;
#(
    parameter int SPR_W      = DEF_SPR_W,
    parameter int SPR_H      = DEF_SPR_H,
    parameter int NUM_FRAMES = 2,
    parameter int ANIM_DIV   = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [1:0]  direction,
    input  logic        moving,
    output logic [2+$clog2(NUM_FRAMES)+$clog2(SPR_H)+$clog2(SPR_W)-1:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic [3:0]  pal_index,
    output logic        out_hit,
    output logic        out_valid
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int AW = 2 + FW + RW + CW;

    // Per-frame shadow state. moving has no shadow register of its own: the
    // animation FSM captures it on the same pulse.
    logic [9:0]    sx_q, sy_q;
    dir_t          dir_q;
    logic [FW-1:0] frame;

    // Datapath registers
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          in_box_q1, in_box_q2;
    logic          pix_valid_q1, pix_valid_q2;

    // Stage 0 combinational signals
    logic [10:0]   dx, dy;
    logic          in_box;
    dir_t          addr_dir;
    logic [CW-1:0] addr_col;
    logic          hit;

    zelda_anim_ctrl #(
        .NUM_FRAMES (NUM_FRAMES),
        .ANIM_DIV   (ANIM_DIV)
    ) u_anim (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .moving      (moving),
        .frame       (frame)
    );

    // Stage 0: box test in 11-bit arithmetic; bit 10 set means the beam is
    // left of / above the sprite, so there is no wrap-around hit.
    always_comb begin
        dx     = {1'b0, draw_x} - {1'b0, sx_q};
        dy     = {1'b0, draw_y} - {1'b0, sy_q};
        in_box = pix_valid
               && !dx[10] && (dx < 11'(SPR_W))
               && !dy[10] && (dy < 11'(SPR_H));

        addr_dir = dir_q;
        addr_col = dx[CW-1:0];
`ifdef MIRROR_LEFT_EN
        if (dir_q == DIR_LEFT) begin
            addr_dir = DIR_RIGHT;
            addr_col = ~dx[CW-1:0];   // SPR_W-1-dx for a power-of-2 width
        end
`endif
        rom_addr_d = {addr_dir, frame, dy[RW-1:0], addr_col};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sx_q         <= '0;
            sy_q         <= '0;
            dir_q        <= DIR_DOWN;
            rom_addr_q   <= '0;
            in_box_q1    <= 1'b0;
            in_box_q2    <= 1'b0;
            pix_valid_q1 <= 1'b0;
            pix_valid_q2 <= 1'b0;
        end else begin
            if (frame_start) begin
                sx_q  <= sprite_x;
                sy_q  <= sprite_y;
                dir_q <= dir_t'(direction);
            end
            // Address only moves for in-box pixels to keep the ROM bus quiet.
            if (in_box) begin
                rom_addr_q <= rom_addr_d;
            end
            in_box_q1    <= in_box;
            pix_valid_q1 <= pix_valid;
            in_box_q2    <= in_box_q1;
            pix_valid_q2 <= pix_valid_q1;
        end
    end

    // Stage 2: ROM data lands this cycle, so the result is combinational off
    // rom_data to hold the 2-cycle latency.
    assign hit       = in_box_q2 && (rom_data != TRANSPARENT_IDX);
    assign pal_index = hit ? rom_data : 4'h0;
    assign out_hit   = hit;
    assign out_valid = pix_valid_q2;
    assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_zelda_sprite_fetch.sv
module tb_zelda_sprite_fetch;

    localparam int SPR_W    = 16;
    localparam int SPR_H    = 16;
    localparam int NF       = 2;
    localparam int ANIM_DIV = 8;
    localparam int AW       = 11;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [9:0]    draw_x = '0;
    logic [9:0]    draw_y = '0;
    logic [9:0]    sprite_x = '0;
    logic [9:0]    sprite_y = '0;
    logic [1:0]    direction = '0;
    logic          moving = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_data = '0;
    logic [3:0]    pal_index;
    logic          out_hit;
    logic          out_valid;

    always #5 Clk = ~Clk;

    // Sync ROM whose content is the low nibble of the address.
    always @(posedge Clk) rom_data <= rom_addr[3:0];

    zelda_sprite_fetch #(
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .NUM_FRAMES (NF),
        .ANIM_DIV   (ANIM_DIV)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .direction   (direction),
        .moving      (moving),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pal_index   (pal_index),
        .out_hit     (out_hit),
        .out_valid   (out_valid)
    );

    typedef struct {
        bit       v;
        bit       hit;
        bit [3:0] pal;
    } pix_t;

    int   checks = 0;
    int   failures = 0;

    // Reference model state: latched sprite, count of consecutive walking
    // pulses, last in-box address, and the two pixels in flight.
    int   m_sx = 0, m_sy = 0, m_dir = 0, m_walk = 0, m_addr = 0;
    pix_t p1 = '{default: 0};
    pix_t p2 = '{default: 0};

    function automatic void eval(input bit pv, input int x, input int y,
                                 output pix_t r, output bit inbox, output int addr);
        int dx, dy, d, col, fr;
        dx    = x - m_sx;
        dy    = y - m_sy;
        d     = m_dir;
        col   = dx;
        fr    = (m_walk / ANIM_DIV) % NF;
        inbox = pv && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H;
`ifdef MIRROR_LEFT_EN
        if (d == 2) begin
            d   = 3;
            col = SPR_W - 1 - dx;
        end
`endif
        addr  = ((d * NF + fr) * SPR_H + dy) * SPR_W + col;
        r.v   = pv;
        r.hit = inbox && ((addr % 16) != 0);
        r.pal = r.hit ? 4'(addr % 16) : 4'h0;
    endfunction

    // One clock cycle: drive the pixel, advance the model, check outputs.
    task automatic tick(input bit fs, input bit pv, input int x, input int y);
        pix_t cur;
        bit   ib;
        int   a;
        int   nsx, nsy, ndir;
        bit   nmov;
        frame_start = fs;
        pix_valid   = pv;
        draw_x      = 10'(x);
        draw_y      = 10'(y);
        nsx  = int'(sprite_x);
        nsy  = int'(sprite_y);
        ndir = int'(direction);
        nmov = moving;
        eval(pv, x, y, cur, ib, a);
        @(posedge Clk);
        if (Reset) begin
            p1     = '{default: 0};
            p2     = '{default: 0};
            m_addr = 0;
            m_sx   = 0;
            m_sy   = 0;
            m_dir  = 0;
            m_walk = 0;
        end else begin
            p2 = p1;
            p1 = cur;
            if (ib) m_addr = a;
            if (fs) begin
                m_sx   = nsx;
                m_sy   = nsy;
                m_dir  = ndir;
                m_walk = nmov ? m_walk + 1 : 0;
            end
        end
        #1;
        checks++;
        assert (out_valid === p2.v) else begin
            failures++;
            $error("FAIL out_valid got=%0b exp=%0b t=%0t", out_valid, p2.v, $time);
        end
        checks++;
        assert (out_hit === p2.hit) else begin
            failures++;
            $error("FAIL out_hit got=%0b exp=%0b t=%0t", out_hit, p2.hit, $time);
        end
        checks++;
        assert (pal_index === p2.pal) else begin
            failures++;
            $error("FAIL pal_index got=%0h exp=%0h t=%0t", pal_index, p2.pal, $time);
        end
        checks++;
        assert (rom_addr === AW'(m_addr)) else begin
            failures++;
            $error("FAIL rom_addr got=%0h exp=%0h t=%0t", rom_addr, AW'(m_addr), $time);
        end
        $display("tick fs=%0b pv=%0b x=%0d y=%0d -> addr=%0h pal=%0h hit=%0b valid=%0b",
                 fs, pv, x, y, rom_addr, pal_index, out_hit, out_valid);
    endtask

    task automatic set_sprite(input int x, input int y, input int d, input bit m);
        sprite_x  = 10'(x);
        sprite_y  = 10'(y);
        direction = 2'(d);
        moving    = m;
    endtask

    initial begin
        int x, y;
        bit fs, pv;

        // Reset state
        Reset = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 1, 5, 5);
        Reset = 1'b0;
        tick(0, 0, 0, 0);

        // Sprite (100,50), DOWN, idle: box edges
        set_sprite(100, 50, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 100, 50);
        tick(0, 1, 99, 50);
        tick(0, 1, 116, 50);
        tick(0, 1, 100, 66);
        tick(0, 1, 105, 55);
        tick(0, 1, 115, 65);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Sprite clipped at the bottom-right corner
        set_sprite(632, 470, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 639, 479);
        checks++;
        assert (rom_addr === 11'h097) else begin
            failures++;
            $error("FAIL corner_addr got=%0h exp=%0h", rom_addr, 11'h097);
        end
        tick(0, 1, 0, 0);
        tick(0, 1, 632, 470);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Left-facing column handling
        set_sprite(100, 50, 2, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 103, 50);
        checks++;
`ifdef MIRROR_LEFT_EN
        assert (rom_addr === 11'h60C) else begin
            failures++;
            $error("FAIL left_addr got=%0h exp=%0h", rom_addr, 11'h60C);
        end
`else
        assert (rom_addr === 11'h403) else begin
            failures++;
            $error("FAIL left_addr got=%0h exp=%0h", rom_addr, 11'h403);
        end
`endif
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Walk animation over 20 frames, then stop at pulse 5 of a new walk
        set_sprite(100, 50, 0, 1);
        for (int p = 1; p <= 20; p++) begin
            if (p == 11) direction = 2'd3;
            tick(1, 0, 0, 0);
            tick(0, 1, 101, 50);
            tick(0, 1, 102, 51);
        end
        tick(0, 0, 0, 0);
        for (int p = 1; p <= 7; p++) begin
            moving = (p != 5);
            tick(1, 0, 0, 0);
            tick(0, 1, 103, 52);
        end
        tick(0, 0, 0, 0);

        // Mid-frame sprite change is ignored; coincident pulse uses old state
        set_sprite(100, 50, 0, 0);
        tick(1, 0, 0, 0);
        sprite_x = 10'd200;
        tick(0, 1, 100, 50);
        tick(0, 1, 201, 50);
        tick(1, 1, 104, 50);
        tick(0, 1, 104, 50);
        tick(0, 1, 204, 50);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Randomised traffic around the sprite
        for (int i = 0; i < 3000; i++) begin
            fs = ($urandom_range(0, 39) == 0);
            if (fs || $urandom_range(0, 99) == 0)
                set_sprite($urandom_range(0, 639), $urandom_range(0, 479),
                           $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
            pv = ($urandom_range(0, 7) != 0);
            x  = m_sx + $urandom_range(0, 23) - 4;
            y  = m_sy + $urandom_range(0, 23) - 4;
            if (x < 0) x = 0;
            if (x > 639) x = 639;
            if (y < 0) y = 0;
            if (y > 479) y = 479;
            Reset = ($urandom_range(0, 499) == 0);
            tick(fs, pv, x, y);
        end
        Reset = 1'b0;

        // Reset mid-line while walking, then restart the walk
        set_sprite(100, 50, 0, 1);
        for (int p = 0; p < 9; p++) tick(1, 0, 0, 0);
        tick(0, 1, 100, 50);
        tick(0, 1, 101, 50);
        Reset = 1'b1;
        tick(0, 1, 102, 50);
        Reset = 1'b0;
        tick(0, 1, 103, 50);
        tick(1, 0, 0, 0);
        tick(0, 1, 101, 50);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
